// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcodes, flag bit positions and control states shared by the ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_ROL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_NAND = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_GT   = 4'd14;
    localparam logic [3:0] OP_EQ   = 4'd15;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_iter_mul.sv
// ============================================================================
// Module   : alu_iter_mul
// Brief    : Shift-add unsigned multiplier, one multiplier bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iter_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int             CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_LAST_CNT = CW'(WIDTH - 1);

    logic                r_busy;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [2*WIDTH-1:0]  r_acc;
    logic [2*WIDTH-1:0]  w_addend;
    logic [2*WIDTH-1:0]  w_acc_next;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

    // The final partial product is folded in combinationally so the caller
    // can capture the full product on the same edge that done is seen.
    assign o_done    = r_busy && (r_cnt == c_LAST_CNT);
    assign o_product = w_acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == c_LAST_CNT) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module   : alu_pipe
// Brief    : Registered 16-op ALU with valid/ready handshakes and NZCV flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [3:0]        alu_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [3:0]        flags
);

    localparam logic [SHW:0] c_WIDTH = (SHW + 1)'(WIDTH);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_result;
    logic [3:0]          r_flags;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_mul_start;
    logic                w_mul_done;
    logic [2*WIDTH-1:0]  w_product;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [SHW-1:0]      w_sh;
    logic [SHW:0]        w_rsh;
    logic [WIDTH-1:0]    w_op_result;
    logic                w_op_c;
    logic                w_op_v;
    logic                w_load;
    logic [WIDTH-1:0]    w_ld_result;
    logic                w_ld_c;
    logic                w_ld_v;
    logic [3:0]          w_ld_flags;

    assign w_in_ready  = !reset && (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_mul_start = w_accept && (alu_sel == OP_MUL);

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
    assign w_sh   = b[SHW-1:0];
    // Complementary rotate distance; a zero rotate shifts by WIDTH, giving 0.
    assign w_rsh  = c_WIDTH - {1'b0, w_sh};

    always_comb begin
        w_op_result = '0;
        w_op_c      = 1'b0;
        w_op_v      = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                w_op_result = w_sum[WIDTH-1:0];
                w_op_c      = w_sum[WIDTH];
                w_op_v      = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_op_result = w_diff[WIDTH-1:0];
                w_op_c      = w_diff[WIDTH];
                w_op_v      = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  w_op_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SHL:  w_op_result = a << w_sh;
            OP_SHR:  w_op_result = a >> w_sh;
            OP_ROL:  w_op_result = (a << w_sh) | (a >> w_rsh);
            OP_ROR:  w_op_result = (a >> w_sh) | (a << w_rsh);
            OP_AND:  w_op_result = a & b;
            OP_OR:   w_op_result = a | b;
            OP_XOR:  w_op_result = a ^ b;
            OP_NOR:  w_op_result = ~(a | b);
            OP_NAND: w_op_result = ~(a & b);
            OP_XNOR: w_op_result = ~(a ^ b);
            OP_GT:   w_op_result = {{(WIDTH-1){1'b0}}, a > b};
            OP_EQ:   w_op_result = {{(WIDTH-1){1'b0}}, a == b};
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_ld_result  = w_op_result;
        w_ld_c       = w_op_c;
        w_ld_v       = w_op_v;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (alu_sel == OP_MUL) begin
                        w_state_next = MUL;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_load       = 1'b1;
                    w_ld_result  = w_product[WIDTH-1:0];
                    w_ld_c       = |w_product[2*WIDTH-1:WIDTH];
                    w_ld_v       = |w_product[2*WIDTH-1:WIDTH];
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        w_ld_flags        = '0;
        w_ld_flags[FLG_N] = w_ld_result[WIDTH-1];
        w_ld_flags[FLG_Z] = (w_ld_result == '0);
        w_ld_flags[FLG_C] = w_ld_c;
        w_ld_flags[FLG_V] = w_ld_v;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A new load wins over a drain on the same edge, keeping full throughput.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_ld_result;
            r_flags     <= w_ld_flags;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    alu_iter_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

`default_nettype wire
